// File: rtl/relax_stage_if.sv
// Handshake and data bundle between the edge-relaxation stage and its neighbours.
// The master modport is the upstream/controller side and the slave modport is the relax stage.
interface relax_stage_if #(
    parameter int WW = 7,
    parameter int AW = 5,
    parameter int EW = 4
);
    localparam int IN_W  = 1 + EW + 2 * AW + 2 * WW;
    localparam int OUT_W = 1 + 2 * AW + WW;

    logic             in_valid;
    logic [IN_W-1:0]  in_1;
    logic [IN_W-1:0]  in_2;
    logic [IN_W-1:0]  in_3;
    logic [IN_W-1:0]  in_4;
    logic             iter_end;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] fwd_1;
    logic [OUT_W-1:0] fwd_2;
    logic [OUT_W-1:0] fwd_3;
    logic [OUT_W-1:0] fwd_4;
    logic             iter_done;
    logic             converged;
    logic [5:0]       iter_count;

    modport master (
        output in_valid, in_1, in_2, in_3, in_4, iter_end,
        input  in_ready, out_valid, fwd_1, fwd_2, fwd_3, fwd_4,
        input  iter_done, converged, iter_count
    );

    modport slave (
        input  in_valid, in_1, in_2, in_3, in_4, iter_end,
        output in_ready, out_valid, fwd_1, fwd_2, fwd_3, fwd_4,
        output iter_done, converged, iter_count
    );
endinterface

// File: rtl/relax_stage.sv
// Four-lane Bellman-Ford edge relaxation: candidate distance per lane, same-destination
// conflict merge within a beat, and per-iteration convergence tracking.
module relax_stage #(
    parameter int WW = 7,
    parameter int AW = 5,
    parameter int EW = 4
) (
    input  logic         clk,
    input  logic         rst,
    relax_stage_if.slave io_bus
);
    localparam int IN_W  = 1 + EW + 2 * AW + 2 * WW;
    localparam int OUT_W = 1 + 2 * AW + WW;
    localparam logic [WW-1:0] INF = {WW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [3:0][IN_W-1:0]  w_in;
    logic [3:0]            w_up;
    logic [3:0][EW-1:0]    w_wij;
    logic [3:0][AW-1:0]    w_i;
    logic [3:0][AW-1:0]    w_j;
    logic [3:0][WW-1:0]    w_wi;
    logic [3:0][WW-1:0]    w_wj;
    logic [3:0][WW:0]      w_sum;
    logic [3:0][WW-1:0]    w_cand;
    logic [3:0]            w_hit;
    logic                  w_accept;

    logic                  r_s1_valid;
    logic [3:0][AW-1:0]    r_s1_i;
    logic [3:0][AW-1:0]    r_s1_j;
    logic [3:0][WW-1:0]    r_s1_wj;
    logic [3:0][WW-1:0]    r_s1_cand;
    logic [3:0]            r_s1_hit;

    logic [3:0]            w_drop;
    logic [3:0]            w_win;

    logic                  r_out_valid;
    logic [3:0][OUT_W-1:0] r_fwd;
    logic                  w_any_up;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_iter_done;
    logic                  r_converged;
    logic [5:0]            r_iter_count;
    logic                  r_changed;

    assign w_in     = {io_bus.in_4, io_bus.in_3, io_bus.in_2, io_bus.in_1};
    assign w_accept = io_bus.in_valid & r_in_ready;

    // Lane field split and candidate distance; infinity on either operand or overflow stays infinity.
    always_comb begin
        w_up   = '0;
        w_wij  = '0;
        w_i    = '0;
        w_j    = '0;
        w_wi   = '0;
        w_wj   = '0;
        w_sum  = '0;
        w_cand = '0;
        w_hit  = '0;
        for (int k = 0; k < 4; k++) begin
            w_up[k]  = w_in[k][IN_W-1];
            w_wij[k] = w_in[k][2*WW+2*AW +: EW];
            w_i[k]   = w_in[k][2*WW+AW +: AW];
            w_j[k]   = w_in[k][2*WW +: AW];
            w_wi[k]  = w_in[k][WW +: WW];
            w_wj[k]  = w_in[k][0 +: WW];
            w_sum[k] = {1'b0, w_wi[k]} + {{(WW + 1 - EW){1'b0}}, w_wij[k]};
            if ((w_wi[k] == INF) || (w_sum[k] >= {1'b0, INF})) begin
                w_cand[k] = INF;
            end else begin
                w_cand[k] = w_sum[k][WW-1:0];
            end
            w_hit[k] = w_up[k] & (w_cand[k] < w_wj[k]);
        end
    end

    // Stage 1 register; beats offered while not ready leave no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_j     <= '0;
            r_s1_wj    <= '0;
            r_s1_cand  <= '0;
            r_s1_hit   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_i    <= w_i;
                r_s1_j    <= w_j;
                r_s1_wj   <= w_wj;
                r_s1_cand <= w_cand;
                r_s1_hit  <= w_hit;
            end else begin
                r_s1_hit  <= '0;
            end
        end
    end

    // Pairwise conflict resolution: the lower candidate survives, ties go to the lower lane.
    always_comb begin
        w_drop = '0;
        for (int a = 0; a < 3; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                w_drop[b] = w_drop[b] | (r_s1_hit[a] & r_s1_hit[b] & (r_s1_j[a] == r_s1_j[b])
                                         & (r_s1_cand[a] <= r_s1_cand[b]));
                w_drop[a] = w_drop[a] | (r_s1_hit[a] & r_s1_hit[b] & (r_s1_j[a] == r_s1_j[b])
                                         & (r_s1_cand[a] > r_s1_cand[b]));
            end
        end
        w_win = r_s1_hit & ~w_drop;
    end

    // Stage 2 register; idle cycles clear only the up bits so other fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_fwd       <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            for (int k = 0; k < 4; k++) begin
                if (r_s1_valid) begin
                    if (w_win[k]) begin
                        r_fwd[k] <= {1'b1, r_s1_i[k], r_s1_j[k], r_s1_cand[k]};
                    end else begin
                        r_fwd[k] <= {1'b0, r_s1_i[k], r_s1_j[k], r_s1_wj[k]};
                    end
                end else begin
                    r_fwd[k][OUT_W-1] <= 1'b0;
                end
            end
        end
    end

    // Any relaxed lane on a presented beat marks the iteration as changed.
    always_comb begin
        w_any_up = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_any_up = w_any_up | r_fwd[k][OUT_W-1];
        end
        w_any_up = w_any_up & r_out_valid;
    end

    // Iteration FSM with convergence bookkeeping; DONE is entered only once the pipeline is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_in_ready   <= 1'b1;
            r_iter_done  <= 1'b0;
            r_converged  <= 1'b0;
            r_iter_count <= 6'd0;
            r_changed    <= 1'b0;
        end else begin
            r_iter_done <= 1'b0;
            if (w_any_up) begin
                r_changed <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (io_bus.iter_end) begin
                        r_state    <= ST_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!r_s1_valid && !r_out_valid) begin
                        r_state     <= ST_DONE;
                        r_iter_done <= 1'b1;
                        r_converged <= ~r_changed;
                        r_changed   <= 1'b0;
                        if (r_iter_count != 6'd63) begin
                            r_iter_count <= r_iter_count + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_RUN;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign io_bus.in_ready   = r_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.fwd_1      = r_fwd[0];
    assign io_bus.fwd_2      = r_fwd[1];
    assign io_bus.fwd_3      = r_fwd[2];
    assign io_bus.fwd_4      = r_fwd[3];
    assign io_bus.iter_done  = r_iter_done;
    assign io_bus.converged  = r_converged;
    assign io_bus.iter_count = r_iter_count;
endmodule

// File: tb/tb_relax_stage.sv
// Scoreboard bench for relax_stage: a per-beat reference model queues expected waves and
// iteration results with their due cycle; a negedge monitor pops and compares.
module tb_relax_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    relax_stage_if u_if ();

    relax_stage u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [28:0] lane [4];
    int          due_q [$];
    logic [71:0] dat_q [$];
    int          idue_q [$];
    logic [6:0]  istat_q [$];
    int          ie_cyc, done_cyc, last_acc, cnt;
    bit          chg;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit exp_ready(input int n);
        return !(n > ie_cyc && n <= done_cyc);
    endfunction

    // Reference: each destination among relaxing lanes keeps only its best (lowest cand, then lowest lane).
    function automatic logic [71:0] model_beat(input logic [28:0] ln [4], output bit anyw);
        int cand [4];
        bit hit [4];
        bit win;
        logic [71:0] r;
        r = '0;
        anyw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int wi, wij, wj;
            wi  = int'(ln[k][13:7]);
            wij = int'(ln[k][27:24]);
            wj  = int'(ln[k][6:0]);
            cand[k] = (wi == 127) ? 127 : ((wi + wij > 127) ? 127 : wi + wij);
            hit[k]  = ln[k][28] && (cand[k] < wj);
        end
        for (int k = 0; k < 4; k++) begin
            win = hit[k];
            for (int m = 0; m < 4; m++) begin
                if (m != k && hit[m] && ln[m][18:14] == ln[k][18:14]
                    && (cand[m] < cand[k] || (cand[m] == cand[k] && m < k))) win = 1'b0;
            end
            if (win) begin
                r[k*18 +: 18] = {1'b1, ln[k][23:19], ln[k][18:14], 7'(cand[k])};
                anyw = 1'b1;
            end else begin
                r[k*18 +: 18] = {1'b0, ln[k][23:19], ln[k][18:14], ln[k][6:0]};
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        due_q.delete(); dat_q.delete(); idue_q.delete(); istat_q.delete();
        ie_cyc = -100; done_cyc = -100; last_acc = -100; cnt = 0; chg = 1'b0;
    endtask

    task automatic step(input bit v, input bit ie);
        int n;
        bit rdy, anyw;
        logic [71:0] e;
        n = cyc;
        rdy = exp_ready(n);
        if (v && rdy) begin
            e = model_beat(lane, anyw);
            due_q.push_back(n + 2);
            dat_q.push_back(e);
            last_acc = n;
            if (anyw) chg = 1'b1;
        end
        if (ie && rdy) begin
            ie_cyc = n;
            done_cyc = (n + 2 > last_acc + 4) ? n + 2 : last_acc + 4;
            cnt = (cnt == 63) ? 63 : cnt + 1;
            idue_q.push_back(done_cyc);
            istat_q.push_back({!chg, 6'(cnt)});
            chg = 1'b0;
        end
        u_if.in_valid = v;
        u_if.in_1 = lane[0]; u_if.in_2 = lane[1]; u_if.in_3 = lane[2]; u_if.in_4 = lane[3];
        u_if.iter_end = ie;
        @(posedge clk); #1;
    endtask

    task automatic set_lane(input int k, input bit up, input int wij, input int i, input int j,
                            input int wi, input int wj);
        lane[k] = {up, 4'(wij), 5'(i), 5'(j), 7'(wi), 7'(wj)};
    endtask

    task automatic rand_lanes(input bit quiet);
        logic [6:0] wi, wj;
        for (int k = 0; k < 4; k++) begin
            wi = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 127));
            wj = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 127));
            lane[k] = {quiet ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), wi, wj};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 72'(u_if.in_ready), 72'd1);
        chk({tag, "_out_valid"}, 72'(u_if.out_valid), 72'd0);
        chk({tag, "_fwd"}, {u_if.fwd_4, u_if.fwd_3, u_if.fwd_2, u_if.fwd_1}, 72'd0);
        chk({tag, "_iter_done"}, 72'(u_if.iter_done), 72'd0);
        chk({tag, "_converged"}, 72'(u_if.converged), 72'd0);
        chk({tag, "_iter_count"}, 72'(u_if.iter_count), 72'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat or an iteration completion.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 72'(u_if.in_ready), 72'(exp_ready(cyc)));
            if (u_if.out_valid) begin
                if (due_q.size() == 0) begin
                    chk("unexpected_out_valid", 72'd1, 72'd0);
                end else begin
                    chk("out_latency", 72'(cyc), 72'(due_q.pop_front()));
                    chk("fwd", {u_if.fwd_4, u_if.fwd_3, u_if.fwd_2, u_if.fwd_1}, dat_q.pop_front());
                end
            end else begin
                chk("idle_up", 72'({u_if.fwd_4[17], u_if.fwd_3[17], u_if.fwd_2[17], u_if.fwd_1[17]}), 72'd0);
            end
            if (u_if.iter_done) begin
                if (idue_q.size() == 0) begin
                    chk("unexpected_iter_done", 72'd1, 72'd0);
                end else begin
                    chk("iter_done_time", 72'(cyc), 72'(idue_q.pop_front()));
                    chk("conv_count", 72'({u_if.converged, u_if.iter_count}), 72'(istat_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bit quiet;
        u_if.in_valid = 1'b0; u_if.iter_end = 1'b0;
        u_if.in_1 = '0; u_if.in_2 = '0; u_if.in_3 = '0; u_if.in_4 = '0;
        for (int k = 0; k < 4; k++) lane[k] = '0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Single-lane relax, non-up lane, infinity source, saturating candidate.
        set_lane(0, 1, 0, 3, 7, 21, 73);
        set_lane(1, 0, 0, 4, 8, 17, 73);
        set_lane(2, 1, 3, 5, 9, 127, 127);
        set_lane(3, 1, 15, 6, 10, 120, 127);
        step(1, 0);
        // Same destination: 21 beats 25; equal 21/21 keeps the lower lane.
        set_lane(0, 1, 0, 1, 25, 21, 100);
        set_lane(1, 1, 5, 2, 25, 20, 100);
        set_lane(2, 1, 0, 3, 9, 21, 90);
        set_lane(3, 1, 1, 4, 9, 20, 90);
        step(1, 0);
        // Higher-lane win: lane 0 cand 30 loses to lane 1 cand 21.
        set_lane(0, 1, 10, 1, 12, 20, 100);
        set_lane(1, 1, 1, 2, 12, 20, 100);
        set_lane(2, 0, 0, 0, 0, 0, 0);
        set_lane(3, 1, 15, 7, 31, 0, 16);
        step(1, 1);
        repeat (6) step(0, 0);

        // Iteration with no relaxing lane converges.
        for (int b = 0; b < 3; b++) begin
            rand_lanes(1'b1);
            step(1, b == 2);
        end
        repeat (6) step(0, 0);

        // Beats and iter_end offered during DRAIN/DONE are ignored.
        rand_lanes(1'b1);
        step(1, 1);
        for (int k = 0; k < 4; k++) set_lane(k, 1, 0, k, k, 5, 100);
        repeat (4) step(1, 1);
        repeat (4) step(0, 0);

        // iter_end with empty pipeline.
        step(0, 1);
        repeat (4) step(0, 0);

        // Reset mid-DRAIN with a beat held in stage 1.
        for (int k = 0; k < 4; k++) set_lane(k, 1, 0, k, k, 5, 100);
        step(1, 1);
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_drain_reset");
        repeat (4) step(0, 0);

        // Randomized traffic with quiet stretches to exercise both convergence outcomes.
        quiet = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) quiet = ~quiet;
            rand_lanes(quiet);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        repeat (10) step(0, 0);
        chk("sb_beats_drained", 72'(due_q.size()), 72'd0);
        chk("sb_iters_drained", 72'(idue_q.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/relax_stage.md
# relax_stage

Four-lane edge-relaxation stage of the Bellman-Ford datapath, directly downstream of the forwarding block. Consumes the 29-bit edge waves it emits, computes candidate distance wi+wij per lane, resolves same-destination conflicts within a beat, and produces the 18-bit update waves fed back into the forwarding block's forwarded-wave inputs. Also tracks per-iteration change status so the controller can detect convergence.

## Interface
- WW, 7: weight width; all-ones (7'h7F) is infinity
- AW, 5: node address width
- EW, 4: edge weight width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat on in_1..in_4 is valid; accepted only when in_ready=1
- in_1..in_4  in  29 each  edge wave: up[28], wij[27:24], i[23:19], j[18:14], wi[13:7], wj[6:0]
- iter_end  in  1  marks end of the current iteration; may coincide with the last in_valid
- in_ready  out  1  high in RUN state only
- out_valid  out  1  fwd_1..fwd_4 carry a beat
- fwd_1..fwd_4  out  18 each  update wave: up[17], i[16:12], j[11:7], wj[6:0]
- iter_done  out  1  one-cycle pulse when an iteration fully drains
- converged  out  1  last completed iteration produced no update
- iter_count  out  6  completed iterations, saturating at 63

## Operation
- Stage 1 (registered): sum = {0,wi} + {0,wij} in 8 bits; cand = 7'h7F if wi==7'h7F or sum>=127, else sum[6:0]; hit_k = up_k & (cand_k < wj_k). Register i, j, wj, cand, hit, s1_valid.
- Stage 2 (registered): merge. For every lane pair a<b with hit_a, hit_b, j_a==j_b: drop b if cand_a <= cand_b, else drop a. Surviving lane: fwd = {1, i, j, cand}. Non-hit or dropped lane: fwd = {0, i, j, wj}.
- When out_valid=0, all fwd up bits are 0; remaining fwd fields hold their last value.
- changed_acc sets on any cycle with out_valid=1 and any fwd up bit=1.
- FSM: RUN -> DRAIN on iter_end sampled in RUN. DRAIN -> DONE when s1_valid=0 and out_valid=0. DONE -> RUN unconditionally.
- Entering DONE: converged <= ~changed_acc; iter_count <= iter_count+1 (hold at 63); changed_acc <= 0. iter_done=1 only in DONE.
- in_valid when in_ready=0: beat dropped, no effect. iter_end outside RUN: ignored.
- Reset: state RUN, pipeline valids 0, changed_acc 0; in-flight beats discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, fwd_1..fwd_4=0, iter_done=0, converged=0, iter_count=0.
- Latency: beat accepted in cycle t -> out_valid and fwd in cycle t+2. Throughput one beat per cycle in RUN.
- iter_end with last in_valid in cycle t: in_ready=0 in t+1..t+4, out_valid in t+2, iter_done in t+4 with new converged/iter_count visible in t+4, in_ready=1 in t+5.
- iter_end in cycle t with pipeline empty: iter_done in t+2, in_ready=1 in t+3.
- Updates from the final beat (out_valid in the last DRAIN cycles) are counted in that iteration's converged.

## Test plan
- Lane 1: up=1, wij=0, wi=21, wj=73 -> two cycles later out_valid=1, fwd_1 = {1, i, j, 7'd21}.
- Lane 1: up=0, wi=17, wij=0, wj=73 -> fwd_1 up=0, wj=7'd73; lane with wi=127, wj=127 -> up=0 (infinity never relaxes); wi=120, wij=15 -> cand saturates 127, no hit.
- Lanes 1,2 j=25, cand 21 and 25, both hit -> fwd_1 up=1, fwd_2 up=0; equal cand 21/21 -> lane 1 wins only.
- Iteration 1 beats with hits, iter_end with last beat -> iter_done one cycle at t+4, converged=0, iter_count=1; iteration 2 no hits -> converged=1, iter_count=2.
- in_valid during DRAIN with hitting lanes -> no out_valid for it, changed_acc unaffected; iter_end during DRAIN ignored.
- rst asserted mid-DRAIN with beat in stage 1 -> next cycle all outputs at reset values, no out_valid, no iter_done.
